// File: rtl/seg7_bank_pkg.sv
// seg7_bank_pkg: register map and CTL field positions shared by the
// seven-segment display bank and any future display peripherals.
//   SEG7_VAL / SEG7_CTL / SEG7_RAW0 : word offsets from the block base
//   CTL_*                           : bit positions inside the CTL register
package seg7_bank_pkg;

  localparam logic [31:0] SEG7_VAL  = 32'd0;
  localparam logic [31:0] SEG7_CTL  = 32'd1;
  localparam logic [31:0] SEG7_RAW0 = 32'd2;

  localparam int CTL_ON_BIT  = 0;
  localparam int CTL_RAW_BIT = 1;
  localparam int CTL_EN_LSB  = 8;
  localparam int CTL_DP_LSB  = 16;

  // Active-low segment bus value that lights nothing.
  localparam logic [7:0] SEG_OFF = 8'hFF;

  typedef logic [7:0] seg_pattern_t;

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: hex nibble to seven-segment glyph, purely combinational.
//   nibble : 4-bit value 0..F
//   segs   : {g,f,e,d,c,b,a}, active-high (b and d drawn lowercase)
module seg7_decode (
  input  logic [3:0] nibble,
  output logic [6:0] segs
);

  always_comb begin
    // NOTE: default assignment first so no path leaves segs unassigned (no latch).
    segs = 7'h00;
    unique case (nibble)
      4'h0: segs = 7'h3F;
      4'h1: segs = 7'h06;
      4'h2: segs = 7'h5B;
      4'h3: segs = 7'h4F;
      4'h4: segs = 7'h66;
      4'h5: segs = 7'h6D;
      4'h6: segs = 7'h7D;
      4'h7: segs = 7'h07;
      4'h8: segs = 7'h7F;
      4'h9: segs = 7'h6F;
      4'hA: segs = 7'h77;
      4'hB: segs = 7'h7C;
      4'hC: segs = 7'h39;
      4'hD: segs = 7'h5E;
      4'hE: segs = 7'h79;
      4'hF: segs = 7'h71;
    endcase
  end

endmodule

// File: rtl/seg7_bank.sv
// seg7_bank: memory-mapped multi-digit seven-segment scan controller.
//   clk     : bus and scan clock
//   reset_n : asynchronous active-low reset
//   enable  : bus enable (0 = ignore writes, release data)
//   rw      : 1 = write, 0 = read
//   addr    : word address; registers at BASE .. BASE+DIGITS+1
//   data    : bidirectional bus, driven only during an addressed read
//   seg     : {dp,g..a}, active-low
//   an      : one anode per digit, active-low
// Registers: VAL (hex value), CTL (ON, RAW, enable mask, dp mask), RAWn.
module seg7_bank
  import seg7_bank_pkg::*;
#(
  parameter logic [11:0] BASE        = 12'h100,
  parameter int          DIGITS      = 4,
  parameter int          PRESCALE    = 50000,
  parameter int          BLANK       = 16,
  parameter logic [31:0] CTL_DEFAULT = 32'h0000_FF01
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              rw,
  input  logic [31:0]       addr,
  inout  wire  [31:0]       data,
  output logic [7:0]        seg,
  output logic [DIGITS-1:0] an
);

  localparam int PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int NREG  = DIGITS + 2;

  localparam logic [PS_W-1:0]  PS_MAX    = PS_W'(PRESCALE - 1);
  localparam logic [PS_W-1:0]  BLANK_END = PS_W'(BLANK);
  localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(DIGITS - 1);

  localparam logic [0:0] ST_BLANKING = 1'b0;
  localparam logic [0:0] ST_SHOW     = 1'b1;

  // ---------------- bus decode ----------------
  logic [31:0]      offset;
  logic             hit;
  logic [IDX_W-1:0] raw_idx;

  assign offset  = addr - 32'(BASE);
  assign hit     = enable && (addr >= 32'(BASE)) && (offset < 32'(NREG));
  assign raw_idx = IDX_W'(offset - SEG7_RAW0);

  // ---------------- registers ----------------
  logic [31:0]       val;
  logic              ctl_on;
  logic              ctl_raw;
  logic [DIGITS-1:0] en_mask;
  logic [DIGITS-1:0] dp_mask;
  seg_pattern_t      raw_seg [DIGITS];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      val     <= '0;
      ctl_on  <= CTL_DEFAULT[CTL_ON_BIT];
      ctl_raw <= CTL_DEFAULT[CTL_RAW_BIT];
      en_mask <= CTL_DEFAULT[CTL_EN_LSB +: DIGITS];
      dp_mask <= CTL_DEFAULT[CTL_DP_LSB +: DIGITS];
      // NOTE: the RAWn array is a handful of flops, not RAM, so it is reset like any register.
      for (int i = 0; i < DIGITS; i++) raw_seg[i] <= '0;
    end else if (hit && rw) begin
      if (offset == SEG7_VAL) begin
        val <= data;
      end else if (offset == SEG7_CTL) begin
        ctl_on  <= data[CTL_ON_BIT];
        ctl_raw <= data[CTL_RAW_BIT];
        en_mask <= data[CTL_EN_LSB +: DIGITS];
        dp_mask <= data[CTL_DP_LSB +: DIGITS];
      end else begin
        raw_seg[raw_idx] <= data[7:0];
      end
    end
  end

  // Read-back: mask bits above DIGITS and unused CTL bits read as zero.
  logic [31:0] rdata;

  always_comb begin
    rdata = '0;
    if (offset == SEG7_VAL) begin
      rdata = val;
    end else if (offset == SEG7_CTL) begin
      rdata[CTL_ON_BIT]           = ctl_on;
      rdata[CTL_RAW_BIT]          = ctl_raw;
      rdata[CTL_EN_LSB +: DIGITS] = en_mask;
      rdata[CTL_DP_LSB +: DIGITS] = dp_mask;
    end else if (offset < 32'(NREG)) begin
      rdata = {24'h0, raw_seg[raw_idx]};
    end
  end

  assign data = (hit && !rw) ? rdata : 'z;

  // ---------------- scan timing ----------------
  logic [PS_W-1:0]  presc;
  logic [IDX_W-1:0] idx;
  logic [0:0]       state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc <= '0;
      idx   <= '0;
    end else if (presc == PS_MAX) begin
      presc <= '0;
      idx   <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // The first BLANK cycles of each slot keep all anodes off so the previous
  // digit's segments have drained before the next anode turns on.
  assign state = (presc < BLANK_END) ? ST_BLANKING : ST_SHOW;

  // ---------------- output stage ----------------
  logic [4:0]   nib_lsb;
  logic [6:0]   glyph;
  seg_pattern_t pattern;
  logic         digit_on;

  assign nib_lsb = 5'({idx, 2'b00});

  seg7_decode u_decode (
    .nibble (val[nib_lsb +: 4]),
    .segs   (glyph)
  );

  assign pattern  = ctl_raw ? raw_seg[idx] : {dp_mask[idx], glyph};
  assign digit_on = ctl_on && en_mask[idx];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg <= SEG_OFF;
      an  <= '1;
    end else if (state == ST_SHOW && digit_on) begin
      seg <= ~pattern;
      an  <= ~(DIGITS'(1) << idx);
    end else begin
      seg <= SEG_OFF;
      an  <= '1;
    end
  end

endmodule

// File: tb/tb_seg7_bank.sv
// tb_seg7_bank: self-checking bench for seg7_bank. Two instances share one
// bus: a 4-digit bank at 0x100 and an 8-digit bank at 0x200. A per-cycle
// scoreboard predicts {an,seg} for both banks from shadow copies of their
// registers; directed bus reads and reset checks run alongside it.
module tb_seg7_bank;

  localparam int P4 = 20;
  localparam int B4 = 4;
  localparam int P8 = 6;
  localparam int B8 = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        enable = 1'b0;
  logic        rw = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] drv = '0;
  logic        drv_oe = 1'b0;
  wire  [31:0] data;
  logic [7:0]  seg4, seg8;
  logic [3:0]  an4;
  logic [7:0]  an8;

  assign data = drv_oe ? drv : 'z;

  always #5 clk = ~clk;

  seg7_bank #(.BASE(12'h100), .DIGITS(4), .PRESCALE(P4), .BLANK(B4),
              .CTL_DEFAULT(32'h0000_FF01)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .rw(rw), .addr(addr),
    .data(data), .seg(seg4), .an(an4));

  seg7_bank #(.BASE(12'h200), .DIGITS(8), .PRESCALE(P8), .BLANK(B8),
              .CTL_DEFAULT(32'h0000_FF01)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .rw(rw), .addr(addr),
    .data(data), .seg(seg8), .an(an8));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  // Expected {an (8 bits, padded with 1s), seg} for output cycle 'cyc' after reset release.
  function automatic logic [15:0] model(input int digits, input int ps, input int blk,
                                        input int cyc, input logic [31:0] v,
                                        input logic [31:0] c, input logic [63:0] r);
    int         pr;
    int         d;
    logic [7:0] pat;
    logic [7:0] an_m;
    pr    = cyc % ps;
    d     = (cyc / ps) % digits;
    model = 16'hFFFF;
    if (pr >= blk && c[0] && c[8 + d]) begin
      pat     = c[1] ? r[8*d +: 8] : {c[16 + d], hex7(v[4*d +: 4])};
      an_m    = 8'hFF;
      an_m[d] = 1'b0;
      model   = {an_m, ~pat};
    end
  endfunction

  logic [31:0] v4, c4, v8, c8;
  logic [63:0] r4, r8;

  task automatic sh_reset();
    v4 = '0; c4 = 32'h0000_FF01; r4 = '0;
    v8 = '0; c8 = 32'h0000_FF01; r8 = '0;
  endtask

  task automatic sh_write(input logic [31:0] a, input logic [31:0] d);
    if (a == 32'h100) v4 = d;
    else if (a == 32'h101) c4 = d;
    else if (a >= 32'h102 && a <= 32'h105) r4[8*int'(a - 32'h102) +: 8] = d[7:0];
    else if (a == 32'h200) v8 = d;
    else if (a == 32'h201) c8 = d;
    else if (a >= 32'h202 && a <= 32'h209) r8[8*int'(a - 32'h202) +: 8] = d[7:0];
  endtask

  // ---------------- scan scoreboard ----------------
  logic [15:0] q4[$];
  logic [15:0] q8[$];
  logic [31:0] rdq[$];
  int          cyc = 0;
  bit          done = 1'b0;

  initial begin : monitor
    logic [15:0] e;
    while (!done) begin
      @(posedge clk);
      if (!reset_n) begin
        cyc = 0;
        q4.push_back(16'hFFFF);
        q8.push_back(16'hFFFF);
      end else begin
        q4.push_back(model(4, P4, B4, cyc, v4, c4, r4));
        q8.push_back(model(8, P8, B8, cyc, v8, c8, r8));
        cyc++;
      end
      @(negedge clk);
      e = q4.pop_front();
      if (!reset_n) e = 16'hFFFF;
      check("scan4", {16'h0, 4'hF, an4, seg4}, {16'h0, e});
      e = q8.pop_front();
      if (!reset_n) e = 16'hFFFF;
      check("scan8", {16'h0, an8, seg8}, {16'h0, e});
    end
  end

  // ---------------- bus tasks ----------------
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic en);
    @(negedge clk);
    enable = en; rw = 1'b1; addr = a; drv = d; drv_oe = 1'b1;
    @(posedge clk);
    #1;
    if (en) sh_write(a, d);
    enable = 1'b0; rw = 1'b0; drv_oe = 1'b0;
  endtask

  // keep=1: the bench drives exp onto the bus itself, so the read only
  // returns exp if no bank drives data.
  task automatic bus_read(input string tag, input logic [31:0] a, input logic en,
                          input logic keep, input logic [31:0] exp);
    @(negedge clk);
    enable = en; rw = 1'b0; addr = a; drv = exp; drv_oe = keep;
    #1;
    rdq.push_back(exp);
    check(tag, data, rdq.pop_front());
    @(posedge clk);
    #1;
    enable = 1'b0; drv_oe = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit found;
    sh_reset();
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_seg4", {24'h0, seg4}, 32'h0000_00FF);
    check("rst_an4",  {28'h0, an4},  32'h0000_000F);
    check("rst_an8",  {24'h0, an8},  32'h0000_00FF);
    reset_n = 1'b1;

    bus_read("rd_ctl4_rst", 32'h101, 1'b1, 1'b0, 32'h0000_0F01);
    bus_read("rd_val4_rst", 32'h100, 1'b1, 1'b0, 32'h0000_0000);
    bus_read("rd_ctl8_rst", 32'h201, 1'b1, 1'b0, 32'h0000_FF01);

    // Hex mode on both banks; two full frames of the 4-digit bank.
    bus_write(32'h100, 32'h0000_1234, 1'b1);
    bus_write(32'h200, 32'hFEDC_BA98, 1'b1);
    bus_read("rd_val4", 32'h100, 1'b1, 1'b0, 32'h0000_1234);
    repeat (2 * 4 * P4) @(posedge clk);

    // Raw mode, digits 0 and 2 enabled; upper RAW0 bits are discarded.
    bus_write(32'h101, 32'h0005_0503, 1'b1);
    bus_write(32'h102, 32'hFFFF_FF3F, 1'b1);
    bus_write(32'h104, 32'h0000_0006, 1'b1);
    bus_read("rd_raw0", 32'h102, 1'b1, 1'b0, 32'h0000_003F);
    bus_read("rd_ctl4", 32'h101, 1'b1, 1'b0, 32'h0005_0503);
    repeat (2 * 4 * P4) @(posedge clk);

    // Bus isolation.
    bus_read("iso_oor4", 32'h106, 1'b1, 1'b1, 32'hA5A5_5A5A);
    bus_read("iso_oor8", 32'h20A, 1'b1, 1'b1, 32'h5A5A_A5A5);
    bus_write(32'h100, 32'hDEAD_BEEF, 1'b0);
    bus_read("iso_noen", 32'h100, 1'b0, 1'b1, 32'h1357_9BDF);
    bus_read("iso_val4", 32'h100, 1'b1, 1'b0, 32'h0000_1234);

    // Async reset in the middle of digit 2's SHOW phase.
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(posedge clk);
      #1;
      if (cyc % (4 * P4) == 2 * P4 + 11) found = 1'b1;
    end
    check("tmo_d2", {31'h0, found}, 32'h1);
    check("pre_rst_an4",  {28'h0, an4},  32'h0000_000B);
    check("pre_rst_seg4", {24'h0, seg4}, 32'h0000_00F9);
    #1 reset_n = 1'b0;
    sh_reset();
    #1;
    check("async_an4",  {28'h0, an4},  32'h0000_000F);
    check("async_seg4", {24'h0, seg4}, 32'h0000_00FF);
    check("async_an8",  {24'h0, an8},  32'h0000_00FF);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < B4; k++) begin
      @(posedge clk);
      #1;
      check("post_rst_blank", {28'h0, an4}, 32'h0000_000F);
    end
    @(posedge clk);
    #1;
    check("post_rst_an4",  {28'h0, an4},  32'h0000_000E);
    check("post_rst_seg4", {24'h0, seg4}, 32'h0000_00C0);

    // 8-digit bank: digit 7 shows F, then the scan wraps to digit 0.
    bus_write(32'h200, 32'hFEDC_BA98, 1'b1);
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(posedge clk);
      #1;
      if (an8 == 8'h7F) found = 1'b1;
    end
    check("tmo_d7", {31'h0, found}, 32'h1);
    check("d7_seg8", {24'h0, seg8}, 32'h0000_008E);
    found = 1'b0;
    for (int k = 0; k < 50 && !found; k++) begin
      @(posedge clk);
      #1;
      if (an8 != 8'hFF && an8 != 8'h7F) found = 1'b1;
    end
    check("tmo_wrap", {31'h0, found}, 32'h1);
    check("wrap_an8",  {24'h0, an8},  32'h0000_00FE);
    check("wrap_seg8", {24'h0, seg8}, 32'h0000_0080);
    bus_read("rd_raw7", 32'h209, 1'b1, 1'b0, 32'h0000_0000);

    done = 1'b1;
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
